// File: rtl/urv_ahb_arbiter.sv
// Shares one AHB-Lite master port between instruction fetch (IM) and load/store (DM).
// Optional starvation guard for IM is enabled by defining URV_AHB_STARVE_GUARD_EN.
module urv_ahb_arbiter
`ifdef URV_AHB_STARVE_GUARD_EN
   #(parameter int unsigned STARVE_MAX = 4)
`endif
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        im_req_i,
   input  logic [31:0] im_addr_i,
   output logic        im_gnt_o,
   output logic [31:0] im_rdata_o,
   output logic        im_valid_o,
   output logic        im_err_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [1:0]  dm_size_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic [31:0] dm_rdata_o,
   output logic        dm_done_o,
   output logic        dm_err_o,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IM   = 2'd1;
   localparam logic [1:0] OWN_DM   = 2'd2;
   localparam logic [1:0] OWN_ERR2 = 2'd3;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   logic        run_q;
   logic [1:0]  own_q, own_d;
   logic        err_dm_q, err_dm_d;
   logic [31:0] hwdata_q, hwdata_d;

   logic busy;
   logic err_first;
   logic addr_block;
   logic force_im;
   logic sel_im, sel_dm;
   logic gnt_im, gnt_dm;

   assign busy      = (own_q == OWN_IM) || (own_q == OWN_DM);
   assign err_first = busy && HRESP && !HREADY;
   // No new address phase while an ERROR response is in flight or before run.
   assign addr_block = !run_q || (busy && HRESP) || (own_q == OWN_ERR2);

`ifdef URV_AHB_STARVE_GUARD_EN
   logic [2:0] cnt_q, cnt_d;

   assign force_im = im_req_i && dm_req_i && (cnt_q == 3'(STARVE_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (gnt_im || !im_req_i)
         cnt_d = 3'd0;
      else if (gnt_dm)
         cnt_d = cnt_q + 3'd1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         cnt_q <= 3'd0;
      else
         cnt_q <= cnt_d;
   end
`else
   assign force_im = 1'b0;
`endif

   assign sel_dm = dm_req_i && !force_im && !addr_block;
   assign sel_im = im_req_i && !sel_dm && !addr_block;
   assign gnt_dm = sel_dm && HREADY && !HRESP;
   assign gnt_im = sel_im && HREADY && !HRESP;

   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'd0:    replicate = {4{d[7:0]}};
         2'd1:    replicate = {2{d[15:0]}};
         default: replicate = d;
      endcase
   endfunction

   always_comb begin
      HTRANS = TRANS_IDLE;
      HADDR  = 32'd0;
      HWRITE = 1'b0;
      HSIZE  = 3'b000;
      if (sel_dm) begin
         HTRANS = TRANS_NONSEQ;
         HADDR  = dm_addr_i;
         HWRITE = dm_we_i;
         HSIZE  = {1'b0, dm_size_i};
      end else if (sel_im) begin
         HTRANS = TRANS_NONSEQ;
         HADDR  = im_addr_i;
         HSIZE  = 3'b010;
      end
   end

   always_comb begin
      own_d    = own_q;
      err_dm_d = err_dm_q;
      hwdata_d = hwdata_q;
      if (err_first) begin
         own_d    = OWN_ERR2;
         err_dm_d = (own_q == OWN_DM);
      end else if (own_q == OWN_ERR2) begin
         if (HREADY)
            own_d = OWN_NONE;
      end else if (gnt_dm) begin
         own_d = OWN_DM;
      end else if (gnt_im) begin
         own_d = OWN_IM;
      end else if (HREADY) begin
         own_d = OWN_NONE;
      end
      if (gnt_dm && dm_we_i)
         hwdata_d = replicate(dm_size_i, dm_wdata_i);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         run_q    <= 1'b0;
         own_q    <= OWN_NONE;
         err_dm_q <= 1'b0;
         hwdata_q <= 32'd0;
      end else begin
         run_q    <= 1'b1;
         own_q    <= own_d;
         err_dm_q <= err_dm_d;
         hwdata_q <= hwdata_d;
      end
   end

   assign im_gnt_o = gnt_im;
   assign dm_gnt_o = gnt_dm;
   assign HWDATA   = hwdata_q;

   assign im_rdata_o = run_q ? HRDATA : 32'd0;
   assign dm_rdata_o = run_q ? HRDATA : 32'd0;

   assign im_valid_o = (own_q == OWN_IM) && HREADY && !HRESP;
   assign dm_done_o  = (own_q == OWN_DM) && HREADY && !HRESP;

   // A one-cycle ERROR (HREADY already high) is reported immediately as well.
   assign im_err_o = HREADY && (((own_q == OWN_ERR2) && !err_dm_q) || ((own_q == OWN_IM) && HRESP));
   assign dm_err_o = HREADY && (((own_q == OWN_ERR2) &&  err_dm_q) || ((own_q == OWN_DM) && HRESP));

endmodule

// File: tb/tb_urv_ahb_arbiter.sv
// Directed bench for urv_ahb_arbiter: fetch, stores, stalled load, error, priority, reset.
module tb_urv_ahb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        im_req_i;
   logic [31:0] im_addr_i;
   logic        im_gnt_o;
   logic [31:0] im_rdata_o;
   logic        im_valid_o;
   logic        im_err_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [31:0] dm_addr_i;
   logic [1:0]  dm_size_i;
   logic [31:0] dm_wdata_i;
   logic        dm_gnt_o;
   logic [31:0] dm_rdata_o;
   logic        dm_done_o;
   logic        dm_err_o;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   urv_ahb_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .im_req_i(im_req_i), .im_addr_i(im_addr_i), .im_gnt_o(im_gnt_o),
      .im_rdata_o(im_rdata_o), .im_valid_o(im_valid_o), .im_err_o(im_err_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_size_i(dm_size_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o), .dm_err_o(dm_err_o),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are checked on the falling edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b0; im_req_i = 1'b0; im_addr_i = 32'd0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'd0; dm_size_i = 2'd0; dm_wdata_i = 32'd0;
      HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0;

      // Reset state
      mid();
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_haddr", HADDR, 32'd0);
      chk("rst_hwdata", HWDATA, 32'd0);
      cyc(); cyc();

      // Reset released; run is still 0 for this cycle
      rst_i = 1'b1; im_req_i = 1'b1; im_addr_i = 32'h100;
      mid();
      chk("prerun_im_gnt", 32'(im_gnt_o), 32'd0);
      chk("prerun_htrans", 32'(HTRANS), 32'd0);

      // IM fetch at 0x100
      cyc(); mid();
      chk("f1_htrans", 32'(HTRANS), 32'd2);
      chk("f1_haddr", HADDR, 32'h100);
      chk("f1_hsize", 32'(HSIZE), 32'd2);
      chk("f1_hwrite", 32'(HWRITE), 32'd0);
      chk("f1_im_gnt", 32'(im_gnt_o), 32'd1);
      chk("f1_dm_gnt", 32'(dm_gnt_o), 32'd0);
      cyc(); im_req_i = 1'b0; HRDATA = 32'h13; mid();
      chk("f2_im_valid", 32'(im_valid_o), 32'd1);
      chk("f2_im_rdata", im_rdata_o, 32'h13);
      chk("f2_htrans", 32'(HTRANS), 32'd0);
      chk("f2_dm_done", 32'(dm_done_o), 32'd0);

      // DM byte store beats a pending IM request
      cyc(); im_req_i = 1'b1; im_addr_i = 32'h104;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h203; dm_size_i = 2'd0; dm_wdata_i = 32'h123456A5;
      mid();
      chk("sb_dm_gnt", 32'(dm_gnt_o), 32'd1);
      chk("sb_im_gnt", 32'(im_gnt_o), 32'd0);
      chk("sb_hsize", 32'(HSIZE), 32'd0);
      chk("sb_hwrite", 32'(HWRITE), 32'd1);
      chk("sb_haddr", HADDR, 32'h203);
      chk("sb_im_valid", 32'(im_valid_o), 32'd0);
      cyc(); dm_req_i = 1'b0; mid();
      chk("sb_hwdata", HWDATA, 32'hA5A5A5A5);
      chk("sb_dm_done", 32'(dm_done_o), 32'd1);
      chk("sb_then_im_gnt", 32'(im_gnt_o), 32'd1);
      chk("sb_then_haddr", HADDR, 32'h104);

      // Back-to-back: fetch completes while a half store is granted
      cyc(); im_req_i = 1'b0; HRDATA = 32'h17;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h300; dm_size_i = 2'd1; dm_wdata_i = 32'hBEEF1234;
      mid();
      chk("sh_im_valid", 32'(im_valid_o), 32'd1);
      chk("sh_im_rdata", im_rdata_o, 32'h17);
      chk("sh_dm_gnt", 32'(dm_gnt_o), 32'd1);
      chk("sh_hsize", 32'(HSIZE), 32'd1);

      // Word load at 0x400 granted while the half store completes
      cyc(); dm_we_i = 1'b0; dm_addr_i = 32'h400; dm_size_i = 2'd2; mid();
      chk("sh_hwdata", HWDATA, 32'h12341234);
      chk("sh_dm_done", 32'(dm_done_o), 32'd1);
      chk("ld_dm_gnt", 32'(dm_gnt_o), 32'd1);
      chk("ld_hwrite", 32'(HWRITE), 32'd0);
      chk("ld_haddr", HADDR, 32'h400);
      cyc(); dm_req_i = 1'b0; HREADY = 1'b0; mid();
      chk("ld_w1_done", 32'(dm_done_o), 32'd0);
      chk("ld_w1_htrans", 32'(HTRANS), 32'd0);
      cyc(); mid();
      chk("ld_w2_done", 32'(dm_done_o), 32'd0);
      chk("ld_w2_hwdata", HWDATA, 32'h12341234);
      cyc(); HREADY = 1'b1; HRDATA = 32'hCAFEF00D; mid();
      chk("ld_done", 32'(dm_done_o), 32'd1);
      chk("ld_rdata", dm_rdata_o, 32'hCAFEF00D);
      cyc(); mid();
      chk("ld_done_once", 32'(dm_done_o), 32'd0);

      // IM fetch answered with a two-cycle ERROR
      cyc(); im_req_i = 1'b1; im_addr_i = 32'h500; mid();
      chk("e0_im_gnt", 32'(im_gnt_o), 32'd1);
      cyc(); im_addr_i = 32'h504; HREADY = 1'b0; HRESP = 1'b1; mid();
      chk("e1_htrans", 32'(HTRANS), 32'd0);
      chk("e1_im_gnt", 32'(im_gnt_o), 32'd0);
      chk("e1_im_err", 32'(im_err_o), 32'd0);
      cyc(); HREADY = 1'b1; mid();
      chk("e2_im_err", 32'(im_err_o), 32'd1);
      chk("e2_im_valid", 32'(im_valid_o), 32'd0);
      chk("e2_im_gnt", 32'(im_gnt_o), 32'd0);
      chk("e2_htrans", 32'(HTRANS), 32'd0);
      cyc(); HRESP = 1'b0; mid();
      chk("e3_im_err", 32'(im_err_o), 32'd0);
      chk("e3_im_valid", 32'(im_valid_o), 32'd0);
      chk("e3_im_gnt", 32'(im_gnt_o), 32'd1);
      cyc(); im_req_i = 1'b0; mid();
      chk("e4_im_valid", 32'(im_valid_o), 32'd1);

      // Continuous DM and IM requests
      cyc(); im_req_i = 1'b1; im_addr_i = 32'h600;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h700; dm_size_i = 2'd2;
      for (int k = 0; k < 8; k++) begin
         logic exp_im;
`ifdef URV_AHB_STARVE_GUARD_EN
         exp_im = (k == 4);
`else
         exp_im = 1'b0;
`endif
         if (k != 0) cyc();
         mid();
         chk($sformatf("pri%0d_im_gnt", k), 32'(im_gnt_o), 32'(exp_im));
         chk($sformatf("pri%0d_dm_gnt", k), 32'(dm_gnt_o), 32'(!exp_im));
      end
      cyc(); im_req_i = 1'b0; dm_req_i = 1'b0; mid();

      // Reset asserted during a stalled load
      cyc(); dm_req_i = 1'b1; dm_addr_i = 32'h800; mid();
      chk("r0_dm_gnt", 32'(dm_gnt_o), 32'd1);
      cyc(); dm_req_i = 1'b0; HREADY = 1'b0; mid();
      chk("r1_dm_done", 32'(dm_done_o), 32'd0);
      #2 rst_i = 1'b0; dm_req_i = 1'b1;
      #1;
      chk("r2_htrans", 32'(HTRANS), 32'd0);
      chk("r2_haddr", HADDR, 32'd0);
      chk("r2_dm_gnt", 32'(dm_gnt_o), 32'd0);
      HREADY = 1'b1;
      #1;
      chk("r2_dm_done", 32'(dm_done_o), 32'd0);
      chk("r2_dm_err", 32'(dm_err_o), 32'd0);
      cyc(); cyc(); rst_i = 1'b1; mid();
      chk("r3_dm_done", 32'(dm_done_o), 32'd0);
      chk("r3_dm_gnt", 32'(dm_gnt_o), 32'd0);
      cyc(); mid();
      chk("r4_dm_gnt", 32'(dm_gnt_o), 32'd1);
      chk("r4_dm_done", 32'(dm_done_o), 32'd0);
      cyc(); dm_req_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
